// File: rtl/piradspi_axis_arbiter_pkg.sv
// piradspi_pkg: shared arbiter state type, index-width helper and round-robin pick function
package piradspi_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} piradspi_arb_state_t;
  localparam int RR_MAX = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // First asserted request after last, wrapping modulo n; scanning from the far end lets the nearest win.
  function automatic logic [3:0] rr_next(input logic [RR_MAX-1:0] req, input logic [3:0] last, input int n);
    logic [3:0] r;
    logic [3:0] j;
    r = last;
    for (int k = RR_MAX; k >= 1; k--) begin
      j = 4'((int'(last) + k) % n);
      if (k <= n && req[j]) r = j;
    end
    return r;
  endfunction
endpackage

// File: rtl/piradspi_axis_arbiter_rr_pick.sv
// piradspi_rr_pick: combinational rotating priority encoder starting just after last_i
module piradspi_rr_pick
  import piradspi_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  assign any_o = |req_i;
  assign idx_o = IDW'(rr_next(RR_MAX'(req_i), 4'(last_i), NREQ));
endmodule

// File: rtl/piradspi_axis_arbiter.sv
// piradspi_axis_arbiter: packet-locked round-robin AXIS merge into the SPI command FIFO.
// Optional stall timeout with forced release is enabled by defining PIRADSPI_ARB_TIMEOUT_EN.
module piradspi_axis_arbiter
  import piradspi_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDW = idx_w(NREQ)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NREQ-1:0]       s_tvalid,
  output logic [NREQ-1:0]       s_tready,
  input  logic [NREQ-1:0]       s_tlast,
  input  logic [NREQ*WIDTH-1:0] s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [WIDTH-1:0]      m_tdata,
  output logic [IDW-1:0]        m_tid,
  output logic                  busy,
  output logic                  timeout_err
);
  piradspi_arb_state_t state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d, last_q, last_d, pick_idx;
  logic pick_any, locked, hs, hs_last, to_hit;
  logic [WIDTH-1:0] sel_data;

  piradspi_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (s_tvalid),
    .last_i(last_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign locked = state_q == ARB_LOCKED;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) if (grant_q == IDW'(i)) sel_data = s_tdata[i*WIDTH +: WIDTH];
  end

  // Pure combinational pass-through of the granted source; outputs are forced quiet while idle.
  assign m_tvalid = locked & s_tvalid[grant_q];
  assign m_tlast  = locked & s_tlast[grant_q];
  assign m_tdata  = locked ? sel_data : '0;
  assign m_tid    = locked ? grant_q : '0;
  assign s_tready = (locked & m_tready) ? (NREQ'(1) << grant_q) : '0;
  assign busy     = locked;
  assign hs       = m_tvalid & m_tready;
  assign hs_last  = hs & m_tlast;

`ifdef PIRADSPI_ARB_TIMEOUT_EN
  localparam int TCW = idx_w(TIMEOUT_CYCLES);
  logic [TCW-1:0] cnt_q, cnt_d;
  assign to_hit      = locked & ~hs & (cnt_q == TCW'(TIMEOUT_CYCLES - 1));
  assign cnt_d       = (locked & ~hs & ~to_hit) ? cnt_q + TCW'(1) : '0;
  assign timeout_err = to_hit;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: if (pick_any) begin
        grant_d = pick_idx;
        state_d = ARB_LOCKED;
      end
      default: if (hs_last || to_hit) begin
        last_d  = grant_q;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // last_q starts at NREQ-1 so requester 0 is the first one served.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_piradspi_axis_arbiter.sv
// tb_piradspi_axis_arbiter: directed checks of locking, fairness, stalls, reset and timeout
module tb_piradspi_axis_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 32;
  localparam int IDW = 2;
  logic aclk = 1'b0;
  logic aresetn;
  logic [NREQ-1:0] s_tvalid, s_tready, s_tlast;
  logic [NREQ*WIDTH-1:0] s_tdata;
  logic m_tvalid, m_tready, m_tlast, busy, timeout_err;
  logic [WIDTH-1:0] m_tdata;
  logic [IDW-1:0] m_tid, cur;
  logic [NREQ-1:0] hs;
  logic first;
  int checks = 0;
  int errors = 0;
  int np;
  int beat [NREQ];
  int exp_seq [6] = '{0, 1, 2, 3, 0, 1};

  always #5 aclk = ~aclk;

  piradspi_axis_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .m_tid(m_tid), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge aclk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    s_tdata[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset;
    aresetn = 1'b0;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    m_tready = 1'b1;
    #2;
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_sready", s_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    nxt;
    nxt;
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // requester 2 sends a 3-beat packet
    do_reset;
    s_tvalid[2] = 1'b1;
    set_data(2, 'hA1);
    #2;
    chk("t1_arb_cycle", m_tvalid, 0);
    nxt; #2;
    chk("t1_b1_valid", m_tvalid, 1);
    chk("t1_b1_tid", m_tid, 2);
    chk("t1_b1_data", m_tdata, 'hA1);
    chk("t1_b1_last", m_tlast, 0);
    chk("t1_b1_sready", s_tready, 4'b0100);
    chk("t1_b1_busy", busy, 1);
    nxt;
    set_data(2, 'hA2);
    #2;
    chk("t1_b2_data", m_tdata, 'hA2);
    chk("t1_b2_tid", m_tid, 2);
    nxt;
    set_data(2, 'hA3);
    s_tlast[2] = 1'b1;
    #2;
    chk("t1_b3_data", m_tdata, 'hA3);
    chk("t1_b3_last", m_tlast, 1);
    nxt;
    s_tvalid[2] = 1'b0;
    s_tlast[2] = 1'b0;
    #2;
    chk("t1_busy_fall", busy, 0);
    chk("t1_mvalid_fall", m_tvalid, 0);

    // all requesters continuously valid, 2-beat packets
    do_reset;
    for (int i = 0; i < NREQ; i++) begin
      beat[i] = 0;
      set_data(i, 32'(i * 256));
    end
    s_tvalid = '1;
    #2;
    np = 0;
    first = 1'b1;
    cur = '0;
    for (int c = 0; c < 40 && np < 6; c++) begin
      if (m_tvalid && m_tready) begin
        if (first) begin
          chk("rr_tid", m_tid, exp_seq[np]);
          np++;
          cur = m_tid;
        end else chk("rr_no_interleave", m_tid, cur);
        chk("rr_data", m_tdata, 32'(m_tid) * 256 + beat[m_tid]);
        first = m_tlast;
      end
      hs = s_tvalid & s_tready;
      nxt;
      for (int i = 0; i < NREQ; i++) if (hs[i]) begin
        beat[i] = 1 - beat[i];
        s_tlast[i] = beat[i] == 1;
        set_data(i, 32'(i * 256 + beat[i]));
      end
      #2;
    end
    chk("rr_count", np, 6);

    // requester 1 locked, m_tready low for 20 cycles mid-packet
    do_reset;
    s_tvalid[1] = 1'b1;
    set_data(1, 'hB1);
    nxt; #2;
    chk("t3_tid", m_tid, 1);
    chk("t3_b1_data", m_tdata, 'hB1);
    nxt;
    set_data(1, 'hB2);
    set_data(0, 'hC0);
    set_data(2, 'hC2);
    set_data(3, 'hC3);
    m_tready = 1'b0;
    s_tvalid = 4'b1111;
    #2;
    for (int k = 0; k < 20; k++) begin
      chk("stall_data", m_tdata, 'hB2);
      chk("stall_tid", m_tid, 1);
      chk("stall_sready", s_tready, 0);
      chk("stall_mvalid", m_tvalid, 1);
      nxt; #2;
    end
    m_tready = 1'b1;
    #1;
    chk("t3_resume_sready", s_tready, 4'b0010);
    chk("t3_resume_data", m_tdata, 'hB2);
    nxt;
    set_data(1, 'hB3);
    s_tlast[1] = 1'b1;
    #2;
    chk("t3_b3_data", m_tdata, 'hB3);
    chk("t3_b3_last", m_tlast, 1);
    nxt;
    s_tvalid[1] = 1'b0;
    s_tlast[1] = 1'b0;
    #2;
    chk("t3_bubble", busy, 0);
    nxt; #2;
    chk("t3_next_grant", m_tid, 2);

    // requester 0 drops tvalid mid-packet while requester 3 waits
    do_reset;
    s_tvalid = 4'b1001;
    set_data(0, 'hC1);
    set_data(3, 'hD1);
    nxt; #2;
    chk("t4_tid", m_tid, 0);
    chk("t4_b1_data", m_tdata, 'hC1);
    nxt;
    s_tvalid[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("drop_mvalid", m_tvalid, 0);
      chk("drop_tid", m_tid, 0);
      chk("drop_busy", busy, 1);
      chk("drop_sready", s_tready, 4'b0001);
      nxt;
    end
    s_tvalid[0] = 1'b1;
    s_tlast[0] = 1'b1;
    set_data(0, 'hC2);
    #2;
    chk("t4_b2_valid", m_tvalid, 1);
    chk("t4_b2_last", m_tlast, 1);
    chk("t4_b2_tid", m_tid, 0);
    nxt;
    s_tvalid[0] = 1'b0;
    s_tlast[0] = 1'b0;
    #2;
    chk("t4_bubble_busy", busy, 0);
    chk("t4_bubble_mvalid", m_tvalid, 0);
    nxt; #2;
    chk("t4_req3_tid", m_tid, 3);
    chk("t4_req3_data", m_tdata, 'hD1);

    // reset asserted mid-packet
    do_reset;
    s_tvalid = 4'b0100;
    set_data(2, 'hE1);
    nxt;
    nxt;
    set_data(2, 'hE2);
    #2;
    chk("t5_pre_data", m_tdata, 'hE2);
    chk("t5_pre_busy", busy, 1);
    aresetn = 1'b0;
    #1;
    chk("t5_rst_mvalid", m_tvalid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_sready", s_tready, 0);
    chk("t5_rst_data", m_tdata, 0);
    chk("t5_rst_last", m_tlast, 0);
    chk("t5_rst_tid", m_tid, 0);
    s_tvalid = 4'b0011;
    set_data(0, 'hF0);
    set_data(1, 'hF1);
    nxt;
    aresetn = 1'b1;
    #2;
    chk("t5_arb_cycle", m_tvalid, 0);
    nxt; #2;
    chk("t5_first_tid", m_tid, 0);
    chk("t5_first_data", m_tdata, 'hF0);

    // requester 1 stalls after beat 1 while requester 2 waits
    do_reset;
    s_tvalid = 4'b0010;
    set_data(1, 'h61);
    set_data(2, 'h62);
    nxt; #2;
    chk("t6_tid", m_tid, 1);
    nxt;
    s_tvalid = 4'b0100;
    for (int k = 1; k <= 16; k++) begin
      #2;
`ifdef PIRADSPI_ARB_TIMEOUT_EN
      chk("to_pulse", timeout_err, k == 16);
`else
      chk("to_none", timeout_err, 0);
`endif
      chk("to_busy", busy, 1);
      nxt;
    end
    s_tvalid = 4'b0110;
    #2;
`ifdef PIRADSPI_ARB_TIMEOUT_EN
    chk("to_idle_busy", busy, 0);
    chk("to_idle_pulse", timeout_err, 0);
    nxt; #2;
    chk("to_next_tid", m_tid, 2);
`else
    chk("to_held_busy", busy, 1);
    chk("to_held_tid", m_tid, 1);
    chk("to_held_valid", m_tvalid, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
